contador_seq_ctrl: RTL and testbench

Command-driven sequencer for the up/down counter datapath. It accepts a sweep command over a valid/ready handshake: mode, lower and upper bound, and sweep count. It then drives the counter between the bounds until the sweep count is met or the run is aborted, and signals completion with a one-cycle pulse. It sits between the control logic and the counter display path, which keeps consuming `saida`.

---
 rtl/contador_pkg.sv | 21 ++
 rtl/contador_ud_core.sv | 24 ++
 rtl/contador_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_contador_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared types and defaults for the counter sweep sequencer.
package contador_pkg;

  localparam int CONTADOR_WIDTH   = 4;
  localparam int CONTADOR_SWEEP_W = 4;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_RUN    = 2'b10,
    ST_FINISH = 2'b11
  } state_t;

endpackage

// File: rtl/contador_ud_core.sv
// Loadable up/down counter; a load takes priority over a count step.
module contador_ud_core #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= dir ? (q - WIDTH'(1)) : (q + WIDTH'(1));
    end
  end

endmodule

// File: rtl/contador_seq_ctrl.sv
// Command-driven sweep sequencer: FSM, bound compare and sweep counting
// around the up/down counter core.
module contador_seq_ctrl
  import contador_pkg::*;
#(
  parameter int WIDTH   = CONTADOR_WIDTH,
  parameter int SWEEP_W = CONTADOR_SWEEP_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_mode,
  input  logic [WIDTH-1:0]   cmd_lo,
  input  logic [WIDTH-1:0]   cmd_hi,
  input  logic [SWEEP_W-1:0] cmd_sweeps,
  input  logic               hold,
  input  logic               abort,
  output logic [WIDTH-1:0]   saida,
  output logic               dir,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t             state;
  mode_t              mode_r;
  logic [WIDTH-1:0]   lo_r;
  logic [WIDTH-1:0]   hi_r;
  logic [SWEEP_W-1:0] sweeps_r;
  logic [SWEEP_W-1:0] sweep_cnt;
  logic [SWEEP_W-1:0] sweep_next;
  logic               dir_r;
  logic               done_r;
  logic               err_r;

  logic               accept;
  logic               cmd_ok;
  logic               run_go;
  logic               at_end;
  logic               last_sweep;

  logic               core_load;
  logic [WIDTH-1:0]   core_val;
  logic               core_en;
  logic               core_dir;
  logic [WIDTH-1:0]   count;

  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign cmd_ok     = (mode_t'(cmd_mode) != MODE_RSVD) && (cmd_lo <= cmd_hi);

  // The endpoint is the bound we are currently heading towards.
  assign at_end     = dir_r ? (count == lo_r) : (count == hi_r);
  assign sweep_next = sweep_cnt + SWEEP_W'(1);
  assign last_sweep = (sweeps_r != '0) && (sweep_next == sweeps_r);
  assign run_go     = (state == ST_RUN) && !abort && !hold;

  // Counter core steering: load the start value, step, or wrap at an endpoint.
  always_comb begin
    core_load = 1'b0;
    core_val  = lo_r;
    core_en   = 1'b0;
    core_dir  = dir_r;
    if ((state == ST_LOAD) && !abort) begin
      core_load = 1'b1;
      core_val  = (mode_r == MODE_DOWN) ? hi_r : lo_r;
    end else if (run_go) begin
      if (!at_end) begin
        core_en = 1'b1;
      end else if (!last_sweep) begin
        case (mode_r)
          MODE_UP: begin
            core_load = 1'b1;
            core_val  = lo_r;
          end
          MODE_DOWN: begin
            core_load = 1'b1;
            core_val  = hi_r;
          end
          MODE_BOUNCE: begin
            // Turn around with no dwell; a zero-width range has nowhere to go.
            if (lo_r != hi_r) begin
              core_en  = 1'b1;
              core_dir = ~dir_r;
            end
          end
          default: begin
            core_load = 1'b0;
          end
        endcase
      end
    end
  end

  contador_ud_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clock    (clock),
    .reset    (reset),
    .load     (core_load),
    .load_val (core_val),
    .en       (core_en),
    .dir      (core_dir),
    .q        (count)
  );

  // Command latch: plain data, only written on an accepted command.
  always_ff @(posedge clock) begin
    if (accept && cmd_ok) begin
      mode_r   <= mode_t'(cmd_mode);
      lo_r     <= cmd_lo;
      hi_r     <= cmd_hi;
      sweeps_r <= cmd_sweeps;
    end
  end

  // Control FSM, direction, sweep count and the done/err pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      dir_r     <= 1'b0;
      sweep_cnt <= '0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (cmd_ok) begin
              state <= ST_LOAD;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            dir_r     <= (mode_r == MODE_DOWN);
            sweep_cnt <= '0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (!hold && at_end) begin
            sweep_cnt <= sweep_next;
            if (last_sweep) begin
              state  <= ST_FINISH;
              done_r <= 1'b1;
            end else if (mode_r == MODE_BOUNCE) begin
              dir_r <= ~dir_r;
            end
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign saida = count;
  assign dir   = dir_r;
  assign done  = done_r;
  assign err   = err_r;

endmodule

// File: tb/tb_contador_seq_ctrl.sv
// Bench for contador_seq_ctrl: directed scenarios plus random commands,
// checked each cycle against a trajectory-based reference model.
module tb_contador_seq_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [3:0] cmd_lo;
  logic [3:0] cmd_hi;
  logic [3:0] cmd_sweeps;
  logic       hold;
  logic       abort;
  logic [3:0] saida;
  logic       dir;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  // Reference model: the run is a precomputed list of counter values
  // (with the direction at each), walked one entry per unheld RUN cycle.
  int traj_v[$];
  int traj_d[$];
  int m_phase = 0;  // 0 idle, 1 load pending, 2 running, 3 finishing
  int m_idx   = 0;
  bit m_finite;
  int m_saida = 0;
  int m_dir   = 0;
  int m_done  = 0;
  int m_err   = 0;

  always #5 clock = ~clock;

  contador_seq_ctrl #(
    .WIDTH   (4),
    .SWEEP_W (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_lo     (cmd_lo),
    .cmd_hi     (cmd_hi),
    .cmd_sweeps (cmd_sweeps),
    .hold       (hold),
    .abort      (abort),
    .saida      (saida),
    .dir        (dir),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void build(int mode, int lo, int hi, int sw);
    int seg = 0;
    traj_v.delete();
    traj_d.delete();
    while ((sw != 0) ? (seg < sw) : (traj_v.size() < 200)) begin
      if (lo == hi) begin
        traj_v.push_back(lo);
        traj_d.push_back((mode == 2) ? (seg % 2) : ((mode == 1) ? 1 : 0));
      end else if (mode == 0) begin
        for (int v = lo; v <= hi; v++) begin traj_v.push_back(v); traj_d.push_back(0); end
      end else if (mode == 1) begin
        for (int v = hi; v >= lo; v--) begin traj_v.push_back(v); traj_d.push_back(1); end
      end else if (seg == 0) begin
        for (int v = lo; v <= hi; v++) begin traj_v.push_back(v); traj_d.push_back(0); end
      end else if (seg % 2 == 1) begin
        for (int v = hi - 1; v >= lo; v--) begin traj_v.push_back(v); traj_d.push_back(1); end
      end else begin
        for (int v = lo + 1; v <= hi; v++) begin traj_v.push_back(v); traj_d.push_back(0); end
      end
      seg++;
    end
  endfunction

  task automatic model_update();
    m_done = 0;
    m_err  = 0;
    if (reset) begin
      m_phase = 0;
      m_saida = 0;
      m_dir   = 0;
    end else begin
      case (m_phase)
        0: if (cmd_valid) begin
          if (cmd_mode == 2'd3 || cmd_lo > cmd_hi) begin
            m_err = 1;
          end else begin
            build(int'(cmd_mode), int'(cmd_lo), int'(cmd_hi), int'(cmd_sweeps));
            m_finite = (cmd_sweeps != 0);
            m_phase  = 1;
          end
        end
        1: if (abort) begin
          m_phase = 0;
        end else begin
          m_idx   = 0;
          m_saida = traj_v[0];
          m_dir   = traj_d[0];
          m_phase = 2;
        end
        2: if (abort) begin
          m_phase = 0;
        end else if (!hold) begin
          if (m_idx >= traj_v.size() - 1) begin
            m_phase = 3;
            m_done  = 1;
          end else begin
            m_idx++;
            m_saida = traj_v[m_idx];
            m_dir   = traj_d[m_idx];
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clock);
    #1;
    chk("saida", 32'(saida), 32'(m_saida));
    chk("dir", 32'(dir), 32'(m_dir));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("cmd_ready", 32'(cmd_ready), 32'(m_phase == 0));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic send_cmd(input int mode, input int lo, input int hi, input int sw);
    cmd_valid  = 1'b1;
    cmd_mode   = 2'(mode);
    cmd_lo     = 4'(lo);
    cmd_hi     = 4'(hi);
    cmd_sweeps = 4'(sw);
    step();
    cmd_valid  = 1'b0;
  endtask

  task automatic run_until_idle(input int max_cycles);
    for (int c = 0; c < max_cycles && busy; c++) step();
    chk("run_bound", 32'(busy), 32'd0);
  endtask

  task automatic run_until_value(input int value, input int max_cycles);
    for (int c = 0; c < max_cycles && saida != 4'(value); c++) step();
    chk("reach_value", 32'(saida), 32'(value));
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_lo = 4'd0;
    cmd_hi = 4'd0; cmd_sweeps = 4'd0; hold = 1'b0; abort = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // UP 2..5 once: 2,3,4,5,5 then done and back to idle.
    send_cmd(0, 2, 5, 1);
    run_until_idle(20);
    chk("up_final", 32'(saida), 32'd5);

    // BOUNCE 3..6 three sweeps ends on 6.
    send_cmd(2, 3, 6, 3);
    run_until_idle(30);
    chk("bounce_final", 32'(saida), 32'd6);

    // DOWN full range twice, then a zero-width range held for four sweeps.
    send_cmd(1, 0, 15, 2);
    run_until_idle(50);
    chk("down_final", 32'(saida), 32'd0);
    send_cmd(1, 7, 7, 4);
    run_until_idle(20);
    chk("flat_final", 32'(saida), 32'd7);

    // Rejected commands: reserved mode and inverted bounds.
    send_cmd(3, 1, 2, 1);
    step();
    send_cmd(0, 9, 4, 1);
    step();
    chk("reject_saida", 32'(saida), 32'd7);

    // Continuous UP with hold at 8 and abort at 12.
    send_cmd(0, 0, 15, 0);
    run_until_value(8, 20);
    hold = 1'b1;
    repeat (3) step();
    hold = 1'b0;
    run_until_value(12, 20);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    chk("abort_saida", 32'(saida), 32'd12);

    // Reset in the middle of a BOUNCE run.
    send_cmd(2, 3, 6, 3);
    run_until_value(5, 20);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_saida", 32'(saida), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    step();

    // Random commands with random hold/abort and stray cmd_valid while busy.
    for (int n = 0; n < 40; n++) begin
      send_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      for (int c = 0; c < 300 && m_phase != 0; c++) begin
        hold       = ($urandom_range(0, 3) == 0);
        abort      = (c > 80) || ($urandom_range(0, 40) == 0);
        cmd_valid  = ($urandom_range(0, 3) == 0);
        cmd_mode   = 2'($urandom_range(0, 3));
        cmd_lo     = 4'($urandom_range(0, 15));
        cmd_hi     = 4'($urandom_range(0, 15));
        cmd_sweeps = 4'($urandom_range(0, 3));
        step();
      end
      hold      = 1'b0;
      abort     = 1'b0;
      cmd_valid = 1'b0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
